aes_round_ctrl: RTL and testbench

Round sequencer for the iterative AES-128 datapath in `aes_cipher_top`. It accepts one block start request at a time through a valid/ready handshake and drives the datapath's load strobe, round index, round enable and last-round select. It presents completion to the downstream output stage through a second valid/ready handshake, with back-to-back block support. It is purely a control block: no data passes through it.

---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/aes_round_ctr.sv | 27 ++
 rtl/aes_round_ctrl.sv | 85 ++++++++
 tb/tb_aes_round_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
// The state type is one-hot; min_rw() gives the narrowest round index for a round count.
package aes_ctrl_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    ROUND = 4'b0100,
    DONE  = 4'b1000
  } aes_ctrl_state_t;

  // Smallest RW with 2**RW > nr.
  function automatic int min_rw(input int nr);
    return $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/aes_round_ctr.sv
// Round counter: loads to 1, increments while enabled, saturates at NR and flags terminal count.
module aes_round_ctr #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  output logic [RW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == RW'(NR));

  // Holding at NR keeps the index valid if the FSM lingers after the last round.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RW'(1);
    end else if (inc && !tc) begin
      cnt <= cnt + RW'(1);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath (LOAD, NR rounds, DONE handshake).
// Optional macro AES_CTRL_BLKCNT_EN adds a 32-bit completed-block counter on blk_cnt.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int RW = min_rw(NR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ld,
  output logic          rnd_en,
  output logic [RW-1:0] rnd_idx,
  output logic          last_rnd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   blk_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready never depends on in_valid; out_valid never depends on out_ready.
  aes_ctrl_state_t state_q, state_d;
  logic [RW-1:0]   cnt;
  logic            tc;

  aes_round_ctr #(.NR(NR), .RW(RW)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == LOAD),
    .inc  (state_q == ROUND),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (tc) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to their reset values for every cycle rst is high, even mid-round.
  always_comb begin
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    ld        = !rst && (state_q == LOAD);
    rnd_en    = !rst && (state_q == ROUND);
    rnd_idx   = rnd_en ? cnt : '0;
    last_rnd  = rnd_en && tc;
    out_valid = !rst && (state_q == DONE);
  end

`ifdef AES_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_q;
  logic        out_fire;

  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (out_fire) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt = rst ? 32'd0 : blk_cnt_q;
`else
  assign blk_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed scenarios plus random traffic
// against a cycle-age reference model and a completion-time queue.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          ld;
  logic          rnd_en;
  logic [RW-1:0] rnd_idx;
  logic          last_rnd;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   blk_cnt;

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld        (ld),
    .rnd_en    (rnd_en),
    .rnd_idx   (rnd_idx),
    .last_rnd  (last_rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  // Reference model: a block in flight is described only by its age in cycles since acceptance.
  bit          m_busy   = 1'b0;
  int          m_age    = 0;
  logic [31:0] m_blk    = 32'd0;
  logic [31:0] exp_q[$];
  bit          ov_seen  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step(input bit iv, input bit ordy, input bit r);
    bit e_ld, e_en, e_last, e_ov, e_ir, acc, fire;
    int e_idx;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    rst       = r;
    #1;
    e_ld   = m_busy && (m_age == 1);
    e_en   = m_busy && (m_age >= 2) && (m_age <= NR + 1);
    e_idx  = e_en ? m_age - 1 : 0;
    e_last = e_en && (m_age == NR + 1);
    e_ov   = m_busy && (m_age == NR + 2);
    e_ir   = !m_busy || (e_ov && ordy);
    if (r) begin
      e_ld = 0; e_en = 0; e_idx = 0; e_last = 0; e_ov = 0; e_ir = 0;
    end
    check("in_ready",  32'(in_ready),  32'(e_ir));
    check("ld",        32'(ld),        32'(e_ld));
    check("rnd_en",    32'(rnd_en),    32'(e_en));
    check("rnd_idx",   32'(rnd_idx),   32'(e_idx));
    check("last_rnd",  32'(last_rnd),  32'(e_last));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("blk_cnt",   blk_cnt,        r ? 32'd0 : m_blk);

    // Completion latency: out_valid must first rise exactly NR+2 cycles after the start.
    if (out_valid && !ov_seen) begin
      if (exp_q.size() > 0) check("ov_latency", 32'(cyc), exp_q.pop_front());
      else check("ov_unexpected", 32'(out_valid), 32'd0);
      ov_seen = 1'b1;
    end
    if (out_valid && ordy) ov_seen = 1'b0;

    acc  = e_ir && iv;
    fire = e_ov && ordy;
    if (r) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_blk  = 32'd0;
      exp_q.delete();
      ov_seen = 1'b0;
    end else begin
`ifdef AES_CTRL_BLKCNT_EN
      if (fire) m_blk = m_blk + 32'd1;
`endif
      if (acc) begin
        m_busy = 1'b1;
        m_age  = 1;
        exp_q.push_back(32'(cyc + NR + 2));
      end else if (fire) begin
        m_busy = 1'b0;
      end else if (m_busy && m_age < NR + 2) begin
        m_age++;
      end
    end
    cyc++;
  endtask

  initial begin
    bit hit;

    // Reset held for a few cycles, then a single block with out_ready high.
    repeat (3) step(1, 1, 1);
    step(1, 1, 0);
    repeat (13) step(0, 1, 0);

    // Output backpressure: five stalled DONE cycles, then consume and return to idle.
    step(1, 0, 0);
    repeat (16) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);

    // Back-to-back blocks: new start accepted in the same cycle the result is consumed.
    step(1, 1, 0);
    repeat (11) step(0, 1, 0);
    step(1, 1, 0);
    repeat (13) step(0, 1, 0);

    // in_valid toggling while busy must not start anything.
    step(1, 1, 0);
    repeat (10) step(1'($urandom_range(0, 1)), 1, 0);
    repeat (4) step(0, 1, 0);

    // Reset in the middle of round 5, then a clean block.
    step(1, 1, 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(0, 1, 0);
      if (rnd_en && rnd_idx == RW'(5)) hit = 1'b1;
    end
    check("reach_rnd5", 32'(hit), 32'd1);
    step(0, 1, 1);
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (14) step(0, 1, 0);

`ifdef AES_CTRL_BLKCNT_EN
    // Counter wrap from all-ones on the next completion.
    @(negedge clk);
    force dut.blk_cnt_q = 32'hFFFF_FFFF;
    m_blk = 32'hFFFF_FFFF;
    step(0, 1, 0);
    release dut.blk_cnt_q;
    step(1, 1, 0);
    repeat (13) step(0, 1, 0);
    check("blk_cnt_wrap", blk_cnt, 32'd0);
`endif

    // Random traffic with random backpressure and occasional reset.
    repeat (1500) step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 199) == 0));

    // Drain any block still in flight.
    repeat (16) step(0, 1, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
